aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- AES-128 round-key generator; the key-schedule stage that feeds the AddRoundKey XOR of the encryption datapath and is sequenced by the round controller.
- Holds the current 128-bit round key and, on request, produces the next round key using one shared S-box over several cycles.
- Reports busy while a new key is in progress, so the controller can stall until the key schedule is complete.

Parameters:
- NR, 10, number of rounds; round index saturates at NR.
- KEY_W, 128, key/round-key width; fixed at 128, other values are unsupported.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- load  input  1  pulse; latch cipher_key as round key 0
- cipher_key  input  128  initial key, byte 0 in bits [127:120]
- next_en  input  1  pulse; request the next round key
- round_key  output  128  current round key
- round_idx  output  4  index of round_key, 0..NR
- busy  output  1  expansion in progress; round_key is stale
- key_valid  output  1  round_key is valid for round_idx
- last  output  1  round_idx == NR

Behaviour:
- Reset (rst=0, asynchronous) clears every output and register:
  - round_key=0, round_idx=0, busy=0, key_valid=0, last=0.
  - FSM returns to IDLE; byte counter cleared to 0.
- Words: w0..w3 = round_key[127:96], [95:64], [63:32], [31:0].
- FSM states: IDLE, SUBW, XORW.
- IDLE:
  - load=1 -> next cycle: round_key=cipher_key, round_idx=0, key_valid=1, stay in IDLE.
  - next_en=1 with key_valid=1 and last=0 -> next cycle: SUBW, byte counter=0, busy=1, key_valid=0.
  - next_en with key_valid=0 or last=1 is ignored; no state change.
- SUBW, 4 cycles with byte counter 0..3:
  - The S-box input is byte b of RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}.
  - The S-box output is written to temp byte b.
  - Counter==3 -> XORW.
- XORW, 1 cycle:
  - t = temp ^ {rcon(round_idx+1), 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Register round_key = {n0,n1,n2,n3}; round_idx += 1; busy=0; key_valid=1 -> IDLE.
- Latency: next_en sampled at edge k gives key_valid=1 with the new key after edge k+5. busy is high for exactly 5 cycles.
- Rcon values for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. Only the top byte of t is affected.
- last = (round_idx == NR), combinational from the registered index.
- Simultaneous load and next_en: load wins and next_en is dropped.
- load during SUBW/XORW aborts the expansion. Next cycle: IDLE, round_key=cipher_key, round_idx=0, busy=0, key_valid=1.
- next_en while busy: ignored; it is not queued.
- round_idx never exceeds NR and never wraps. Only load returns it to 0.
- Reset mid-expansion: all registers cleared immediately; partial temp is discarded.
- All arithmetic is GF(2) XOR; there is no carry anywhere.

Decomposition:
- Shared package aes_pkg:
  - Constants AES_NR=10 and AES_KEY_W=128.
  - Rcon table/function rcon(idx) covering 1..10.
  - FSM state encoding for this block: IDLE, SUBW, XORW.
- One sub-module aes_sbox:
  - Combinational 8-bit forward S-box.
  - The same module is reused by the SubBytes datapath.
  - Instantiated once here.

Test Plan:
- Reset then load with cipher_key=2b7e151628aed2a6abf7158809cf4f3c -> next cycle round_key equals it, round_idx=0, key_valid=1, busy=0.
- After that load, pulse next_en -> busy high for 5 cycles, then round_key=a0fafe1788542cb123a339392a6c7605, round_idx=1.
- Issue 10 next_en pulses, each waiting for key_valid -> round 10 key=d014f9a8c9ee2589e13f0cc8b6630ca6, last=1. An 11th next_en leaves the key and round_idx unchanged and busy stays 0.
- Pulse next_en again during the 3rd busy cycle -> ignored; exactly one round advance, round 1 key correct.
- Pulse load during SUBW, and separately assert load and next_en together -> round_key=cipher_key, round_idx=0, busy=0 in both cases.
- Drive rst low mid-expansion (round 4, SUBW) -> outputs cleared asynchronously before the next edge. After release, a fresh load plus 1 next_en yields a0fafe17... again.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant lookup and key-schedule FSM encoding.
package aes_pkg;

   localparam int unsigned AES_NR    = 10;
   localparam int unsigned AES_KEY_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUBW = 2'd1,
      XORW = 2'd2
   } kx_state_t;

   // Round constant for rounds 1..10; any other index yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] p2, p4, p8, p16, p32, p64, p128;
   logic [7:0] inv;

   // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero without special-casing.
   always_comb begin
      p2   = gf_mul(data, data);
      p4   = gf_mul(p2, p2);
      p8   = gf_mul(p4, p4);
      p16  = gf_mul(p8, p8);
      p32  = gf_mul(p16, p16);
      p64  = gf_mul(p32, p32);
      p128 = gf_mul(p64, p64);
      inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                    gf_mul(gf_mul(p32, p64), p128));
   end

   always_comb begin
      sub = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
   end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 round-key generator: one shared S-box, one SubWord byte per cycle, then a single XOR cycle.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int unsigned NR    = AES_NR,
   parameter int unsigned KEY_W = AES_KEY_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [KEY_W-1:0] cipher_key,
   input  logic             next_en,
   output logic [KEY_W-1:0] round_key,
   output logic [3:0]       round_idx,
   output logic             busy,
   output logic             key_valid,
   output logic             last
);

   kx_state_t  state, state_nx;
   logic [1:0] byte_cnt;
   logic [31:0] temp;
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot;
   logic [7:0]  sbox_in, sbox_out;
   logic [31:0] t, n0, n1, n2, n3;
   logic        start;

   assign w0  = round_key[127:96];
   assign w1  = round_key[95:64];
   assign w2  = round_key[63:32];
   assign w3  = round_key[31:0];
   assign rot = {w3[23:0], w3[31:24]};

   assign last  = (round_idx == 4'(NR));
   assign start = next_en && key_valid && !last;

   always_comb begin
      sbox_in = '0;
      case (byte_cnt)
         2'd0: sbox_in = rot[31:24];
         2'd1: sbox_in = rot[23:16];
         2'd2: sbox_in = rot[15:8];
         2'd3: sbox_in = rot[7:0];
         default: sbox_in = '0;
      endcase
   end

   aes_sbox u_sbox (
      .data (sbox_in),
      .sub  (sbox_out)
   );

   always_comb begin
      t  = temp ^ {rcon(round_idx + 4'd1), 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state logic; load overrides everything, including an expansion in flight
   always_comb begin
      state_nx = state;
      if (load) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nx = SUBW;
            SUBW:    if (byte_cnt == 2'd3) state_nx = XORW;
            XORW:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      case (state)
         SUBW, XORW: busy = 1'b1;
         default:    busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         round_key <= '0;
         round_idx <= '0;
         key_valid <= 1'b0;
         byte_cnt  <= '0;
         temp      <= '0;
      end else if (load) begin
         round_key <= cipher_key;
         round_idx <= '0;
         key_valid <= 1'b1;
         byte_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  key_valid <= 1'b0;
                  byte_cnt  <= '0;
               end
            end
            SUBW: begin
               case (byte_cnt)
                  2'd0: temp[31:24] <= sbox_out;
                  2'd1: temp[23:16] <= sbox_out;
                  2'd2: temp[15:8]  <= sbox_out;
                  2'd3: temp[7:0]   <= sbox_out;
                  default: temp <= temp;
               endcase
               byte_cnt <= byte_cnt + 2'd1;
            end
            XORW: begin
               round_key <= {n0, n1, n2, n3};
               if (round_idx != 4'(NR)) round_idx <= round_idx + 4'd1;
               key_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander against a FIPS-197 style key-schedule model.
module tb_aes_key_expander;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [127:0] cipher_key = '0;
   logic         next_en = 1'b0;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         busy, key_valid, last;

   aes_key_expander #(.NR(10), .KEY_W(128)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .cipher_key (cipher_key),
      .next_en    (next_en),
      .round_key  (round_key),
      .round_idx  (round_idx),
      .busy       (busy),
      .key_valid  (key_valid),
      .last       (last)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   logic [7:0] sbox_tab [256];

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv = 0;
      logic [7:0] c = 8'h63;
      logic [7:0] r;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return r;
   endfunction

   function automatic logic [7:0] rcon_ref(input int r);
      logic [7:0] v = 8'h01;
      for (int i = 1; i < r; i++) v = xt(v);
      return v;
   endfunction

   function automatic logic [127:0] next_key_ref(input logic [127:0] k, input int r);
      logic [31:0] w [4];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      tmp = {w[3][23:0], w[3][31:24]};
      tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
      tmp ^= {rcon_ref(r), 24'h0};
      w[0] ^= tmp;
      for (int i = 1; i < 4; i++) w[i] ^= w[i-1];
      return {w[0], w[1], w[2], w[3]};
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic         lst;
   } exp_t;

   exp_t exp_q[$];
   logic [127:0] m_key = '0;
   int           m_idx = 0;
   bit           m_valid = 0;
   bit           pending = 0;

   logic load_seen = 1'b0;
   logic last_busy = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) load_seen <= 1'b0;
      else      load_seen <= load;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         last_busy = 1'b0;
      end else begin
         if (load_seen || (last_busy && !busy && key_valid)) begin
            if (exp_q.size() == 0) begin
               check("mon_unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("mon_round_key", round_key, e.key);
               check("mon_round_idx", 128'(round_idx), 128'(e.idx));
               check("mon_key_valid", 128'(key_valid), 1);
               check("mon_busy", 128'(busy), 0);
               check("mon_last", 128'(last), 128'(e.lst));
            end
         end
         last_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp();
      exp_t e;
      e.key = m_key;
      e.idx = 4'(m_idx);
      e.lst = (m_idx == 10);
      exp_q.push_back(e);
   endtask

   task automatic do_load(input logic [127:0] k, input bit with_next);
      exp_t dropped;
      load = 1'b1;
      next_en = with_next;
      cipher_key = k;
      if (pending) begin
         dropped = exp_q.pop_back();
         pending = 0;
      end
      m_key = k;
      m_idx = 0;
      m_valid = 1;
      push_exp();
      tick();
      load = 1'b0;
      next_en = 1'b0;
      check("load_busy_low", 128'(busy), 0);
      check("load_idx_zero", 128'(round_idx), 0);
   endtask

   // extra_at: busy cycle (1..5) in which a further next_en is pulsed; 0 = none
   task automatic do_next(input int extra_at);
      bit accepted;
      int cyc;
      accepted = m_valid && (m_idx != 10);
      if (accepted) begin
         m_idx++;
         m_key = next_key_ref(m_key, m_idx);
         push_exp();
      end
      next_en = 1'b1;
      tick();
      next_en = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         if (cyc == extra_at) next_en = 1'b1;
         tick();
         next_en = 1'b0;
      end
      check(accepted ? "busy_cycles" : "ignored_no_busy", 128'(cyc), accepted ? 5 : 0);
      check("next_round_idx", 128'(round_idx), 128'(m_idx));
      check("next_round_key", round_key, m_key);
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   initial begin
      exp_t dropped;
      int n;
      for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

      #1;
      check("reset_round_key", round_key, 0);
      check("reset_flags", {round_idx, busy, key_valid, last}, 0);
      tick();
      rst = 1'b1;
      tick();

      // next_en with no valid key is ignored
      do_next(0);

      // FIPS-197 vector through all ten rounds
      do_load(FIPS_KEY, 0);
      check("fips_load_key", round_key, FIPS_KEY);
      do_next(0);
      check("fips_round1", round_key, FIPS_R1);
      for (int r = 2; r <= 10; r++) do_next(0);
      check("fips_round10", round_key, FIPS_R10);
      check("fips_last", 128'(last), 1);
      do_next(0);
      check("sat_last_still", 128'(last), 1);

      // next_en pulsed during the 3rd busy cycle must not queue a second advance
      do_load(FIPS_KEY, 0);
      do_next(3);
      repeat (3) tick();
      check("extra_pulse_busy", 128'(busy), 0);
      check("extra_pulse_key", round_key, FIPS_R1);

      // load aborts an expansion in SUBW
      do_next(0);
      m_idx++;
      m_key = next_key_ref(m_key, m_idx);
      push_exp();
      pending = 1;
      next_en = 1'b1;
      tick();
      next_en = 1'b0;
      tick();
      do_load(FIPS_KEY, 0);
      check("abort_key", round_key, FIPS_KEY);
      repeat (6) tick();
      check("abort_stays_idle", 128'(busy), 0);

      // simultaneous load and next_en: load wins
      do_next(0);
      do_load(FIPS_KEY, 1);
      check("load_next_key", round_key, FIPS_KEY);
      repeat (2) tick();
      check("load_next_no_busy", 128'(busy), 0);

      // asynchronous reset in the middle of round 4
      for (int r = 1; r <= 3; r++) do_next(0);
      next_en = 1'b1;
      tick();
      next_en = 1'b0;
      tick();
      exp_q.delete();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_key", round_key, 0);
      check("async_rst_flags", {round_idx, busy, key_valid, last}, 0);
      m_valid = 0;
      m_idx = 0;
      m_key = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      do_load(FIPS_KEY, 0);
      do_next(0);
      check("post_reset_round1", round_key, FIPS_R1);

      // randomized keys, gaps, stray pulses and occasional aborts
      for (int it = 0; it < 8; it++) begin
         do_load({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1);
         n = $urandom_range(1, 11);
         for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_next($urandom_range(0, 5));
         end
         if ($urandom_range(0, 2) == 0 && m_idx != 10) begin
            m_idx++;
            m_key = next_key_ref(m_key, m_idx);
            push_exp();
            pending = 1;
            next_en = 1'b1;
            tick();
            next_en = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
            do_load({$urandom, $urandom, $urandom, $urandom}, 0);
            do_next(0);
         end
      end

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("scoreboard_drained", 128'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
